// File: rtl/pam4_slicer_mer.sv
// 4-PAM symbol slicer with block-adaptive reference level and MER error-power averaging.
// Three-edge pipeline per symbol: sample (E0), slice + |y| accumulate (E1), e^2 accumulate / block close (E2).
module pam4_slicer_mer #(
   parameter int                      WIDTH    = 18,
   parameter int                      LOG2_N   = 10,
   parameter logic signed [WIDTH-1:0] REF_INIT = 18'sd16384
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sam_en,
   input  logic signed [WIDTH-1:0] y_in,
   output logic [1:0]              sym,
   output logic signed [WIDTH-1:0] dec_val,
   output logic signed [WIDTH-1:0] err,
   output logic                    dec_valid,
   output logic signed [WIDTH-1:0] ref_lvl,
   output logic [WIDTH-1:0]        err_pow,
   output logic                    blk_done
);
   localparam int AW = WIDTH + LOG2_N;
   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
      logic signed [WIDTH+1:0] hi;
      logic signed [WIDTH+1:0] lo;
      hi = {{3{1'b0}}, {(WIDTH-1){1'b1}}};
      lo = {{3{1'b1}}, {(WIDTH-1){1'b0}}};
      if (v > hi) sat = SMAX;
      else if (v < lo) sat = SMIN;
      else sat = v[WIDTH-1:0];
   endfunction

   // The most negative code has no positive twin, so it folds onto full scale.
   function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
      if (v == SMIN) abs_sat = SMAX;
      else if (v[WIDTH-1]) abs_sat = -v;
      else abs_sat = v;
   endfunction

   logic signed [WIDTH-1:0]   y_r;
   logic                      v1;
   logic                      v2;
   logic [AW-1:0]             acc_abs;
   logic [AW-1:0]             acc_err;
   logic [LOG2_N-1:0]         sym_cnt;

   logic signed [WIDTH+1:0]   y_x;
   logic signed [WIDTH+1:0]   b_x;
   logic signed [WIDTH+1:0]   two_b;
   logic signed [WIDTH+1:0]   three_b;
   logic signed [WIDTH+1:0]   dv_x;
   logic [1:0]                sym_n;
   logic signed [WIDTH-1:0]   dec_n;
   logic signed [WIDTH:0]     err_w;
   logic signed [WIDTH-1:0]   err_n;
   logic signed [2*WIDTH-1:0] sq;
   logic [WIDTH-1:0]          e2;
   logic [AW:0]               err_sum;
   logic                      blk_last;

   // Slicer decision, decided level and error for the held sample
   always_comb begin
      y_x     = {{2{y_r[WIDTH-1]}}, y_r};
      b_x     = {2'b00, ref_lvl};
      two_b   = b_x <<< 1;
      three_b = b_x + two_b;
      sym_n   = 2'b00;
      dv_x    = b_x;
      if (!y_r[WIDTH-1]) begin
         sym_n = (y_x >= two_b) ? 2'b11 : 2'b10;
      end else begin
         sym_n = (y_x < -two_b) ? 2'b00 : 2'b01;
      end
      case (sym_n)
         2'b11:   dv_x = three_b;
         2'b10:   dv_x = b_x;
         2'b01:   dv_x = -b_x;
         default: dv_x = -three_b;
      endcase
      dec_n = sat(dv_x);
      err_w = {y_r[WIDTH-1], y_r} - {dec_n[WIDTH-1], dec_n};
      err_n = sat({err_w[WIDTH], err_w});
   end

   // Error power term and block-close values
   always_comb begin
      sq       = err * err;
      e2       = WIDTH'(sq >> (WIDTH-1));
      err_sum  = {1'b0, acc_err} + {{(LOG2_N+1){1'b0}}, e2};
      blk_last = (sym_cnt == {LOG2_N{1'b1}});
   end

   // Sample capture and registered slicer outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         y_r       <= {WIDTH{1'b0}};
         v1        <= 1'b0;
         sym       <= 2'b00;
         dec_val   <= {WIDTH{1'b0}};
         err       <= {WIDTH{1'b0}};
         dec_valid <= 1'b0;
      end else begin
         v1        <= sam_en;
         dec_valid <= v1;
         if (sam_en) begin
            y_r <= y_in;
         end
         if (v1) begin
            sym     <= sym_n;
            dec_val <= dec_n;
            err     <= err_n;
         end
      end
   end

   // Block accumulators, symbol counter and per-block reference/error-power update
   always_ff @(posedge clk) begin
      if (!reset) begin
         v2       <= 1'b0;
         acc_abs  <= {AW{1'b0}};
         acc_err  <= {AW{1'b0}};
         sym_cnt  <= {LOG2_N{1'b0}};
         ref_lvl  <= REF_INIT;
         err_pow  <= {WIDTH{1'b0}};
         blk_done <= 1'b0;
      end else begin
         v2       <= v1;
         blk_done <= v2 && blk_last;
         if (v2) begin
            if (blk_last) begin
               err_pow <= WIDTH'(err_sum >> LOG2_N);
               ref_lvl <= WIDTH'(acc_abs >> (LOG2_N+1));
               acc_abs <= {AW{1'b0}};
               acc_err <= {AW{1'b0}};
               sym_cnt <= {LOG2_N{1'b0}};
            end else begin
               acc_err <= err_sum[AW-1:0];
               sym_cnt <= sym_cnt + {{(LOG2_N-1){1'b0}}, 1'b1};
            end
         end else if (v1) begin
            acc_abs <= acc_abs + {{LOG2_N{1'b0}}, abs_sat(y_r)};
         end else begin
            acc_abs <= acc_abs;
         end
      end
   end
endmodule

// File: tb/tb_pam4_slicer_mer.sv
// Scoreboard bench for pam4_slicer_mer: a nominal instance (REF_INIT=16384) and a
// saturation instance (REF_INIT=60000), both with 4-symbol blocks.
module tb_pam4_slicer_mer;
   logic clk = 1'b0;
   logic reset = 1'b0;

   logic               sam_en_a = 1'b0, sam_en_b = 1'b0;
   logic signed [17:0] y_a = 18'sd0, y_b = 18'sd0;
   logic [1:0]         sym_a, sym_b;
   logic signed [17:0] dec_a, dec_b, err_a, err_b, ref_a, ref_b;
   logic [17:0]        pow_a, pow_b;
   logic               dv_a, dv_b, bd_a, bd_b;

   typedef struct { int s; int d; int e; } dec_t;
   typedef struct { int p; int r; } blk_t;
   dec_t dq_a[$], dq_b[$];
   blk_t bq_a[$], bq_b[$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pam4_slicer_mer #(.WIDTH(18), .LOG2_N(2), .REF_INIT(18'sd16384)) dut_a (
      .clk(clk), .reset(reset), .sam_en(sam_en_a), .y_in(y_a),
      .sym(sym_a), .dec_val(dec_a), .err(err_a), .dec_valid(dv_a),
      .ref_lvl(ref_a), .err_pow(pow_a), .blk_done(bd_a));

   pam4_slicer_mer #(.WIDTH(18), .LOG2_N(2), .REF_INIT(18'sd60000)) dut_b (
      .clk(clk), .reset(reset), .sam_en(sam_en_b), .y_in(y_b),
      .sym(sym_b), .dec_val(dec_b), .err(err_b), .dec_valid(dv_b),
      .ref_lvl(ref_b), .err_pow(pow_b), .blk_done(bd_b));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pop an expectation whenever a DUT presents a decision or block result
   always @(negedge clk) begin
      dec_t d;
      blk_t b;
      if (dv_a) begin
         if (dq_a.size() == 0) check("a_unexpected_dec", 1, 0);
         else begin
            d = dq_a.pop_front();
            check("a_sym", int'(sym_a), d.s);
            check("a_dec_val", int'(dec_a), d.d);
            check("a_err", int'(err_a), d.e);
         end
      end
      if (bd_a) begin
         if (bq_a.size() == 0) check("a_unexpected_blk", 1, 0);
         else begin
            b = bq_a.pop_front();
            check("a_err_pow", int'(pow_a), b.p);
            check("a_ref_lvl", int'(ref_a), b.r);
         end
      end
      if (dv_b) begin
         if (dq_b.size() == 0) check("b_unexpected_dec", 1, 0);
         else begin
            d = dq_b.pop_front();
            check("b_sym", int'(sym_b), d.s);
            check("b_dec_val", int'(dec_b), d.d);
            check("b_err", int'(err_b), d.e);
         end
      end
      if (bd_b) begin
         if (bq_b.size() == 0) check("b_unexpected_blk", 1, 0);
         else begin
            b = bq_b.pop_front();
            check("b_err_pow", int'(pow_b), b.p);
            check("b_ref_lvl", int'(ref_b), b.r);
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic send_a(input int y, input int s, input int d, input int e);
      dec_t x;
      x.s = s; x.d = d; x.e = e;
      dq_a.push_back(x);
      @(negedge clk);
      sam_en_a = 1'b1;
      y_a = 18'(y);
      @(negedge clk);
      sam_en_a = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic send_b(input int y, input int s, input int d, input int e);
      dec_t x;
      x.s = s; x.d = d; x.e = e;
      dq_b.push_back(x);
      @(negedge clk);
      sam_en_b = 1'b1;
      y_b = 18'(y);
      @(negedge clk);
      sam_en_b = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic blk_a(input int p, input int r);
      blk_t x;
      x.p = p; x.r = r;
      bq_a.push_back(x);
   endtask

   task automatic blk_b(input int p, input int r);
      blk_t x;
      x.p = p; x.r = r;
      bq_b.push_back(x);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset(3);
      check("rst_sym", int'(sym_a), 0);
      check("rst_dec_val", int'(dec_a), 0);
      check("rst_err", int'(err_a), 0);
      check("rst_err_pow", int'(pow_a), 0);
      check("rst_dec_valid", int'(dv_a), 0);
      check("rst_blk_done", int'(bd_a), 0);
      check("rst_ref_lvl", int'(ref_a), 16384);
      check("rst_ref_lvl_b", int'(ref_b), 60000);

      // Slicing with b=16384; y=0 is the non-negative inner boundary and closes the block
      send_a(40000, 3, 49152, -9152);
      send_a(-10000, 1, -16384, 6384);
      send_a(-40000, 0, -49152, 9152);
      blk_a(909, 11250);
      send_a(0, 2, 16384, -16384);
      do_reset(3);
      check("rst2_ref_lvl", int'(ref_a), 16384);
      check("rst2_err_pow", int'(pow_a), 0);

      // Block 1: exact levels
      send_a(16384, 2, 16384, 0);
      send_a(-16384, 1, -16384, 0);
      send_a(49152, 3, 49152, 0);
      blk_a(0, 16384);
      send_a(-49152, 0, -49152, 0);

      // Block 2: constant 20000
      send_a(20000, 2, 16384, 3616);
      send_a(20000, 2, 16384, 3616);
      send_a(20000, 2, 16384, 3616);
      blk_a(99, 10000);
      send_a(20000, 2, 16384, 3616);

      // Block 3 with b=10000: y == 2b and y == -2b boundaries, then reset mid-block
      send_a(20000, 3, 30000, -10000);
      send_a(-20000, 1, -10000, -10000);
      do_reset(1);
      check("rst3_ref_lvl", int'(ref_a), 16384);
      check("rst3_err_pow", int'(pow_a), 0);

      // Fresh block after reset: only these four symbols count
      send_a(8192, 2, 16384, -8192);
      send_a(-8192, 1, -16384, 8192);
      send_a(30000, 2, 16384, 13616);
      blk_a(963, 9548);
      send_a(-30000, 1, -16384, -13616);

      // Saturation instance, b=60000
      send_b(131071, 3, 131071, 0);
      send_b(-131072, 0, -131072, 0);
      send_b(1, 2, 60000, -59999);
      blk_b(13732, 32767);
      send_b(0, 2, 60000, -60000);

      for (int i = 0; i < 50 && (dq_a.size() + dq_b.size() + bq_a.size() + bq_b.size()) != 0; i++)
         @(negedge clk);
      check("drain_dec_a", dq_a.size(), 0);
      check("drain_blk_a", bq_a.size(), 0);
      check("drain_dec_b", dq_b.size(), 0);
      check("drain_blk_b", bq_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
